// File: rtl/receiver.sv
// -----------------------------------------------------------------------------
// receiver: serial receive end of the UART link.
//
// Recovers frames of the form start(0), d1..d7, d0, stop(1), stop(1), one bit
// per CLKS_PER_BIT clocks. The byte is put back into data[7:0] order and
// handed to the local consumer over a four-phase req/ack handshake.
//
// Ports
//   clk   in   1  system clock, all state updates on posedge
//   clr   in   1  synchronous reset, active-low
//   rcv   in   1  serial line, asynchronous to clk, idles high
//   ack   in   1  consumer acknowledge, four-phase
//   data  out  8  received byte, valid while req=1, held until next delivery
//   req   out  1  byte available
//   ferr  out  1  one-cycle pulse: first stop bit sampled 0, frame discarded
//   ovr   out  1  sticky overrun: frame completed while handshake busy
//   busy  out  1  receive FSM not idle
// -----------------------------------------------------------------------------
module receiver #(
    parameter int unsigned DIVIDE = 580,
    parameter int unsigned TICKS  = 9
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       rcv,
    input  logic       ack,
    output logic [7:0] data,
    output logic       req,
    output logic       ferr,
    output logic       ovr,
    output logic       busy
);

    localparam int unsigned CLKS_PER_BIT = DIVIDE * TICKS;
    localparam int unsigned HALF         = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = 13;
    localparam int unsigned IDX_W        = 3;
    localparam int unsigned BYTE_W       = 8;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(7);

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } r_state_t;

    typedef enum logic [1:0] {
        H_IDLE    = 2'd0,
        H_WAIT_HI = 2'd1,
        H_WAIT_LO = 2'd2
    } h_state_t;

    // ------------------------------------------------------------------
    // Input synchronizer and start-edge detection
    // ------------------------------------------------------------------
    logic       sync1;
    logic       sync2;
    logic       rs_prev;
    logic [1:0] flush;
    logic       armed;
    logic       rs;
    logic       fall_c;

    assign rs = sync2;

    // flush marks when sync2 holds a real line sample rather than its reset
    // value; armed requires one genuine high sample, so a line held low
    // through reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (!clr) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rs_prev <= 1'b1;
            flush   <= 2'b00;
            armed   <= 1'b0;
        end else begin
            sync1   <= rcv;
            sync2   <= sync1;
            rs_prev <= sync2;
            flush   <= {flush[0], 1'b1};
            if (flush[1] && sync2) begin
                armed <= 1'b1;
            end
        end
    end

    assign fall_c = armed & rs_prev & ~rs;

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    r_state_t           r_state;
    r_state_t           r_next;
    logic [CNT_W-1:0]   cyc;
    logic [IDX_W-1:0]   idx;
    logic [BYTE_W-1:0]  shreg;
    logic               half_end_c;
    logic               bit_end_c;
    logic               cyc_clr_c;
    logic               cyc_inc_c;
    logic               idx_clr_c;
    logic               shift_c;
    logic               deliver_c;
    logic               ferr_c;
    logic [IDX_W-1:0]   slot_bit_c;

    assign half_end_c = (cyc == HALF_LAST);
    assign bit_end_c  = (cyc == BIT_LAST);
    // Wire slot k carries data bit (k+1) mod 8; 3-bit add wraps slot 7 to d0.
    assign slot_bit_c = idx + IDX_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    // Next-state logic
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE: begin
                if (fall_c) begin
                    r_next = R_START;
                end
            end
            R_START: begin
                if (half_end_c) begin
                    r_next = rs ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (bit_end_c && (idx == IDX_LAST)) begin
                    r_next = R_STOP;
                end
            end
            R_STOP: begin
                if (bit_end_c) begin
                    r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Control strobes for the bit-timing datapath
    always_comb begin
        cyc_clr_c = 1'b0;
        cyc_inc_c = 1'b0;
        idx_clr_c = 1'b0;
        shift_c   = 1'b0;
        deliver_c = 1'b0;
        ferr_c    = 1'b0;
        case (r_state)
            R_IDLE: begin
                cyc_clr_c = 1'b1;
                idx_clr_c = 1'b1;
            end
            R_START: begin
                if (half_end_c) begin
                    cyc_clr_c = 1'b1;
                    idx_clr_c = 1'b1;
                end else begin
                    cyc_inc_c = 1'b1;
                end
            end
            R_DATA: begin
                if (bit_end_c) begin
                    cyc_clr_c = 1'b1;
                    shift_c   = 1'b1;
                end else begin
                    cyc_inc_c = 1'b1;
                end
            end
            R_STOP: begin
                if (bit_end_c) begin
                    cyc_clr_c = 1'b1;
                    deliver_c = rs;
                    ferr_c    = ~rs;
                end else begin
                    cyc_inc_c = 1'b1;
                end
            end
            default: begin
                cyc_clr_c = 1'b1;
                idx_clr_c = 1'b1;
            end
        endcase
    end

    // Cycle counter, slot index and byte assembly
    always_ff @(posedge clk) begin
        if (!clr) begin
            cyc   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            if (cyc_clr_c) begin
                cyc <= '0;
            end else if (cyc_inc_c) begin
                cyc <= cyc + CNT_W'(1);
            end
            if (idx_clr_c) begin
                idx <= '0;
            end else if (shift_c) begin
                idx <= idx + IDX_W'(1);
            end
            if (shift_c) begin
                shreg[slot_bit_c] <= rs;
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    h_state_t h_state;
    h_state_t h_next;
    logic     accept_c;
    logic     ovr_set_c;

    // A delivery is taken when the consumer side is idle, or when it is
    // just finishing the handshake (ack already low) on the same cycle.
    always_comb begin
        accept_c  = 1'b0;
        ovr_set_c = 1'b0;
        if (deliver_c) begin
            if ((h_state == H_IDLE) || ((h_state == H_WAIT_LO) && !ack)) begin
                accept_c = 1'b1;
            end else begin
                ovr_set_c = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!clr) begin
            h_state <= H_IDLE;
        end else begin
            h_state <= h_next;
        end
    end

    // Next-state logic
    always_comb begin
        h_next = h_state;
        case (h_state)
            H_IDLE: begin
                if (accept_c) begin
                    h_next = H_WAIT_HI;
                end
            end
            H_WAIT_HI: begin
                if (ack) begin
                    h_next = H_WAIT_LO;
                end
            end
            H_WAIT_LO: begin
                if (accept_c) begin
                    h_next = H_WAIT_HI;
                end else if (!ack) begin
                    h_next = H_IDLE;
                end
            end
            default: h_next = H_IDLE;
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (!clr) begin
            data <= '0;
            req  <= 1'b0;
            ferr <= 1'b0;
            ovr  <= 1'b0;
            busy <= 1'b0;
        end else begin
            if (accept_c) begin
                data <= shreg;
            end
            req  <= (h_next == H_WAIT_HI);
            ferr <= ferr_c;
            if (ovr_set_c) begin
                ovr <= 1'b1;
            end
            busy <= (r_next != R_IDLE);
        end
    end

endmodule
